// File: rtl/lcg_backstep_if.sv
// Request/response bundle for lcg_backstep. Valid/ready: load and step are
// accepted only on a rising edge where ready is high; out_valid is a one-cycle pulse.
interface lcg_backstep_if #(
    parameter int WIDTH = 16
);
    logic             load;
    logic [WIDTH-1:0] seed;
    logic             step;
    logic [WIDTH-1:0] a_inv;
    logic [WIDTH-1:0] c;
    logic             ready;
    logic [WIDTH-1:0] x_out;
    logic             out_valid;
    logic [1:0]       dbg_state;

    modport master (
        output load, seed, step, a_inv, c,
        input  ready, x_out, out_valid, dbg_state
    );

    modport slave (
        input  load, seed, step, a_inv, c,
        output ready, x_out, out_valid, dbg_state
    );
endinterface

// File: rtl/lcg_backstep.sv
// Rewinds one MDCLCG step: x = a_inv*(x' - c) mod 2^WIDTH, using a
// bit-serial shift-add multiply whose accumulator adder is a Kogge-Stone prefix tree.
module lcg_pfx_black (
    input  logic gh,
    input  logic ph,
    input  logic gl,
    input  logic pl,
    output logic g,
    output logic p
);
    assign g = gh | (ph & gl);
    assign p = ph & pl;
endmodule

module lcg_pfx_grey (
    input  logic gh,
    input  logic ph,
    input  logic gl,
    output logic g
);
    assign g = gh | (ph & gl);
endmodule

module lcg_backstep #(
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    lcg_backstep_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam int LV = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SUB  = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] ainv_q, ainv_d;
    logic [WIDTH-1:0] c_q, c_d;

    logic [WIDTH-1:0] addend;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] acc_next;
    logic             unused_pfx;

    assign addend = d_q << cnt_q;

    // Level 0 is bitwise generate/propagate; each later level doubles the span.
    for (genvar lv = 0; lv <= LV; lv++) begin : g_lvl
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        if (lv == 0) begin : g_init
            assign g = acc_q & addend;
            assign p = acc_q ^ addend;
        end else begin : g_comb
            localparam int D = 1 << (lv - 1);
            for (genvar i = 0; i < WIDTH; i++) begin : g_bit
                if (i < D) begin : g_pass
                    assign g[i] = g_lvl[lv-1].g[i];
                    assign p[i] = g_lvl[lv-1].p[i];
                end else if (i < 2 * D) begin : g_grey
                    lcg_pfx_grey u_grey (
                        .gh (g_lvl[lv-1].g[i]),
                        .ph (g_lvl[lv-1].p[i]),
                        .gl (g_lvl[lv-1].g[i-D]),
                        .g  (g[i])
                    );
                    // Prefix is complete here; propagate is carried only to keep the tree regular.
                    assign p[i] = g_lvl[lv-1].p[i];
                end else begin : g_black
                    lcg_pfx_black u_black (
                        .gh (g_lvl[lv-1].g[i]),
                        .ph (g_lvl[lv-1].p[i]),
                        .gl (g_lvl[lv-1].g[i-D]),
                        .pl (g_lvl[lv-1].p[i-D]),
                        .g  (g[i]),
                        .p  (p[i])
                    );
                end
            end
        end
    end

    assign sum        = {g_lvl[LV].g[WIDTH-2:0], 1'b0} ^ g_lvl[0].p;
    assign unused_pfx = ^{g_lvl[LV].p, g_lvl[LV].g[WIDTH-1]};
    assign acc_next   = ainv_q[cnt_q] ? sum : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            acc_q   <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            ainv_q  <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            acc_q   <= acc_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            ainv_q  <= ainv_d;
            c_q     <= c_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        acc_d   = acc_q;
        d_d     = d_q;
        cnt_d   = cnt_q;
        ainv_d  = ainv_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: begin
                if (bus.load) begin
                    x_d = bus.seed;
                end else if (bus.step) begin
                    ainv_d  = bus.a_inv;
                    c_d     = bus.c;
                    state_d = S_SUB;
                end
            end
            S_SUB: begin
                d_d     = x_q - c_q;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_MUL;
            end
            S_MUL: begin
                acc_d = acc_next;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    x_d     = acc_next;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.ready     = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.x_out     = x_q;
    assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_lcg_backstep.sv
// Bench for lcg_backstep: vector table, hand-written corner sequences and
// randomized/chained backsteps against an arithmetic reference model.
module tb_lcg_backstep;
    localparam int W = 16;
    localparam logic [W-1:0] AINV5 = 16'hCCCD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lcg_backstep_if #(.WIDTH(W)) bus ();

    lcg_backstep #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;
    int unsigned step_cyc = 0;
    logic [W-1:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] seed;
        logic [W-1:0] ainv;
        logic [W-1:0] c;
        logic [W-1:0] exp;
    } vec_t;
    vec_t vecs[8];

    function automatic logic [W-1:0] ref_back(logic [W-1:0] x, logic [W-1:0] ainv, logic [W-1:0] c);
        logic [63:0] prod;
        prod = 64'(ainv) * (64'(x) - 64'(c));
        return prod[W-1:0];
    endfunction

    function automatic logic [W-1:0] ref_fwd(logic [W-1:0] x);
        logic [31:0] t;
        t = 32'd5 * 32'(x) + 32'd1;
        return t[W-1:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_load(input logic [W-1:0] seed);
        @(negedge clk);
        bus.load = 1'b1;
        bus.seed = seed;
        @(posedge clk);
        #1 bus.load = 1'b0;
    endtask

    task automatic start_step(input logic [W-1:0] ainv, input logic [W-1:0] c);
        @(negedge clk);
        bus.step  = 1'b1;
        bus.a_inv = ainv;
        bus.c     = c;
        @(posedge clk);
        #1 bus.step = 1'b0;
        step_cyc = cyc;
    endtask

    task automatic wait_result(input string name, output logic [W-1:0] res);
        int n;
        bit got;
        n   = 0;
        got = 1'b0;
        res = '0;
        while (n < 64 && !got) begin
            @(negedge clk);
            n++;
            if (n == 1) check({name, " busy"}, 32'(bus.ready), 32'd0);
            if (bus.out_valid) got = 1'b1;
        end
        check({name, " done"}, 32'(got), 32'd1);
        if (got) begin
            check({name, " latency"}, cyc - step_cyc, W + 1);
            res = bus.x_out;
            @(negedge clk);
            check({name, " pulse"}, 32'(bus.out_valid), 32'd0);
            check({name, " ready"}, 32'(bus.ready), 32'd1);
        end
    endtask

    task automatic run_step(input string name, input logic [W-1:0] ainv, input logic [W-1:0] c,
                            output logic [W-1:0] res);
        start_step(ainv, c);
        wait_result(name, res);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] x;
        logic [W-1:0] seed;
        logic [W-1:0] ai;
        logic [W-1:0] cc;
        logic [W-1:0] e;
        int bad;

        vecs[0] = '{16'h0006, AINV5,   16'h0001, 16'h0001};
        vecs[1] = '{16'h0000, AINV5,   16'h0001, 16'h3333};
        vecs[2] = '{16'h1234, 16'h0001, 16'h0000, 16'h1234};
        vecs[3] = '{16'hBEEF, 16'h0000, 16'h0007, 16'h0000};
        vecs[4] = '{16'h0002, 16'hFFFF, 16'h0000, 16'hFFFE};
        vecs[5] = '{16'h0005, 16'h0002, 16'h0007, 16'hFFFC};
        vecs[6] = '{16'h8000, 16'h8000, 16'h0000, 16'h0000};
        vecs[7] = '{16'hFFFF, 16'h0003, 16'hFFFF, 16'h0000};

        rst = 1'b1;
        bus.load = 1'b0; bus.step = 1'b0; bus.seed = '0; bus.a_inv = '0; bus.c = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset x_out", 32'(bus.x_out), 32'd0);
        check("reset ready", 32'(bus.ready), 32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            do_load(vecs[i].seed);
            @(negedge clk);
            check($sformatf("vec%0d load", i), 32'(bus.x_out), 32'(vecs[i].seed));
            run_step($sformatf("vec%0d", i), vecs[i].ainv, vecs[i].c, res);
            check($sformatf("vec%0d x_out", i), 32'(res), 32'(vecs[i].exp));
        end

        // load and step together: load wins, step dropped
        do_load(16'h1111);
        @(negedge clk);
        bus.load = 1'b1; bus.seed = 16'h2222; bus.step = 1'b1; bus.a_inv = AINV5; bus.c = 16'h0001;
        @(posedge clk);
        #1 bus.load = 1'b0; bus.step = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid || !bus.ready) bad++;
        end
        check("load+step idle", 32'(bad), 32'd0);
        check("load+step x_out", 32'(bus.x_out), 32'h2222);

        // requests and operand changes mid-MUL are ignored
        start_step(AINV5, 16'h0001);
        repeat (5) @(negedge clk);
        bus.load = 1'b1; bus.seed = 16'hAAAA; bus.step = 1'b1; bus.a_inv = 16'h0000; bus.c = 16'h0005;
        @(posedge clk);
        #1 bus.load = 1'b0; bus.step = 1'b0;
        wait_result("busy ignore", res);
        check("busy ignore x_out", 32'(res), 32'(ref_back(16'h2222, AINV5, 16'h0001)));

        // reset at cnt=7 aborts
        do_load(16'h0006);
        start_step(AINV5, 16'h0001);
        repeat (9) @(negedge clk);
        check("abort in MUL", 32'(bus.dbg_state), 32'd2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort x_out", 32'(bus.x_out), 32'd0);
        check("abort ready", 32'(bus.ready), 32'd1);
        bad = 0;
        repeat (W + 3) begin
            @(negedge clk);
            if (bus.out_valid) bad++;
        end
        check("abort no valid", 32'(bad), 32'd0);
        do_load(16'h0006);
        run_step("after abort", AINV5, 16'h0001, res);
        check("after abort x_out", 32'(res), 32'h0001);

        for (int i = 0; i < 40; i++) begin
            seed = W'($urandom);
            ai   = W'($urandom);
            cc   = W'($urandom_range(0, 3) == 0 ? 0 : $urandom);
            do_load(seed);
            run_step($sformatf("rand%0d", i), ai, cc, res);
            check($sformatf("rand%0d x_out", i), 32'(res), 32'(ref_back(seed, ai, cc)));
        end

        seed = W'($urandom);
        do_load(seed);
        x = seed;
        for (int i = 0; i < 1000; i++) begin
            exp_q.push_back(ref_back(x, AINV5, 16'h0001));
            run_step("chain", AINV5, 16'h0001, res);
            e = exp_q.pop_front();
            if (res !== e) check($sformatf("chain%0d x_out", i), 32'(res), 32'(e));
            else checks++;
            x = e;
        end
        check("chain final x_out", 32'(bus.x_out), 32'(x));
        for (int i = 0; i < 1000; i++) x = ref_fwd(x);
        check("chain round trip", 32'(x), 32'(seed));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
